// File: rtl/seq_shift_add_mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// State encodings are common to the other sequential multipliers and dividers.
package seq_shift_add_mul_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StFix  = 2'd2,
        StDone = 2'd3
    } mul_state_e;

endpackage

// File: rtl/mul_sign_abs.sv
// Conditional two's-complement negate: res = neg ? -val : val.
// Gives |x| when neg is the sign bit, or applies the product sign.
module mul_sign_abs #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] val,
    input  logic             neg,
    output logic [WIDTH-1:0] res
);

    assign res = neg ? -val : val;

endmodule

// File: rtl/seq_shift_add_mul.sv
// Radix-2 sequential shift-add multiplier, signed/unsigned at runtime, fixed WIDTH+1 cycle latency.
// Valid/ready on both sides; the product is held in out until the next operation completes.
module seq_shift_add_mul
    import seq_shift_add_mul_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out
);

    mul_state_e state_q, state_d;

    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               neg_q;
    logic               mode_q;
    logic [2*WIDTH-1:0] out_q;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] prod;
    logic               last_iter;

    mul_sign_abs #(.WIDTH(WIDTH)) u_abs_a (
        .val (a),
        .neg (signed_mode & a[WIDTH-1]),
        .res (a_mag)
    );

    mul_sign_abs #(.WIDTH(WIDTH)) u_abs_b (
        .val (b),
        .neg (signed_mode & b[WIDTH-1]),
        .res (b_mag)
    );

    mul_sign_abs #(.WIDTH(2 * WIDTH)) u_neg_prod (
        .val (acc_q),
        .neg (mode_q & neg_q),
        .res (prod)
    );

    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid)  state_d = StCalc;
            StCalc:  if (last_iter) state_d = StFix;
            StFix:                  state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default:                state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        out       = out_q;
    end

    // Multiplicand is shifted in place each iteration, equivalent to mcand << cnt.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            mode_q   <= 1'b0;
            out_q    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        mode_q   <= signed_mode;
                        mcand_q  <= {{WIDTH{1'b0}}, a_mag};
                        mplier_q <= b_mag;
                        neg_q    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc_q    <= '0;
                        cnt_q    <= '0;
                    end
                end
                StCalc: begin
                    if (mplier_q[0]) begin
                        acc_q <= acc_q + mcand_q;
                    end
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CNT_W'(1);
                end
                StFix: begin
                    out_q <= prod;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
